grf_mp: RTL and testbench

- Parametrised general-purpose register file with multiple read ports, two write ports and a per-register pending-write scoreboard.
- Sits in the D stage of the pipelined CPU.
- Read data is internally forwarded from same-cycle writes.
- Busy bits feed the hazard unit: a register is busy from the cycle its producer issues until it is written back.

---
 rtl/grf_mp_if.sv | 35 +++
 rtl/grf_mp.sv | 101 ++++++++++
 tb/tb_grf_mp.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/grf_mp_if.sv
// Bus bundle for grf_mp: read ports, two write ports, issue port and busy count.
// The driving side (decode/writeback) uses master; the register file uses slave.
interface grf_mp_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned NUM_RD = 2
);
   localparam int unsigned PC_W  = 32;
   localparam int unsigned CNT_W = ADDR_W + 1;

   logic [NUM_RD*ADDR_W-1:0] rd_addr;
   logic [NUM_RD*DATA_W-1:0] rd_data;
   logic [NUM_RD-1:0]        rd_busy;
   logic                     we0;
   logic [ADDR_W-1:0]        wa0;
   logic [DATA_W-1:0]        wd0;
   logic [PC_W-1:0]          wpc0;
   logic                     we1;
   logic [ADDR_W-1:0]        wa1;
   logic [DATA_W-1:0]        wd1;
   logic [PC_W-1:0]          wpc1;
   logic                     iss_en;
   logic [ADDR_W-1:0]        iss_addr;
   logic [CNT_W-1:0]         busy_cnt;

   modport master (
      output rd_addr, we0, wa0, wd0, wpc0, we1, wa1, wd1, wpc1, iss_en, iss_addr,
      input  rd_data, rd_busy, busy_cnt
   );

   modport slave (
      input  rd_addr, we0, wa0, wd0, wpc0, we1, wa1, wd1, wpc1, iss_en, iss_addr,
      output rd_data, rd_busy, busy_cnt
   );
endinterface

// File: rtl/grf_mp.sv
// Multi-read, dual-write register file with same-cycle forwarding and a pending-write scoreboard.
// Optional macro GRF_TRACE_EN prints one trace line per committed write.
module grf_mp #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned NUM_RD = 2
) (
   input  logic   clk,
   input  logic   reset,
   grf_mp_if.slave bus
);
   localparam int unsigned DEPTH = 2 ** ADDR_W;
   localparam int unsigned CNT_W = ADDR_W + 1;

   logic [DATA_W-1:0] regs_q [DEPTH];
   logic [DATA_W-1:0] regs_d [DEPTH];
   logic [DEPTH-1:0]  busy_q, busy_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              we0_eff, we1_eff, iss_eff;

   // Writes and issues are inert while reset is held, so nothing leaks through forwarding.
   always_comb begin
      we0_eff = bus.we0 && !reset && (bus.wa0 != '0);
      we1_eff = bus.we1 && !reset && (bus.wa1 != '0);
      iss_eff = bus.iss_en && !reset && (bus.iss_addr != '0);
   end

   // Port 1 is applied last so it wins a same-address conflict.
   always_comb begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
         regs_d[i] = regs_q[i];
      end
      if (we0_eff) regs_d[bus.wa0] = bus.wd0;
      if (we1_eff) regs_d[bus.wa1] = bus.wd1;
   end

   // Clear on write-back first, then set on issue so a new producer wins.
   always_comb begin
      busy_d = busy_q;
      if (we0_eff) busy_d[bus.wa0] = 1'b0;
      if (we1_eff) busy_d[bus.wa1] = 1'b0;
      if (iss_eff) busy_d[bus.iss_addr] = 1'b1;
      cnt_d = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         cnt_d = cnt_d + CNT_W'(busy_d[i]);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            regs_q[i] <= '0;
         end
         busy_q <= '0;
         cnt_q  <= '0;
      end else begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            regs_q[i] <= regs_d[i];
         end
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
      end
   end

   // Zero-latency read with write forwarding; forwarded data also masks the busy flag.
   always_comb begin
      logic [ADDR_W-1:0] ra;
      logic              hit0, hit1;
      bus.rd_data = '0;
      bus.rd_busy = '0;
      for (int unsigned k = 0; k < NUM_RD; k++) begin
         ra   = bus.rd_addr[k*ADDR_W +: ADDR_W];
         hit0 = we0_eff && (bus.wa0 == ra);
         hit1 = we1_eff && (bus.wa1 == ra);
         if (ra == '0) begin
            bus.rd_data[k*DATA_W +: DATA_W] = '0;
         end else if (hit1) begin
            bus.rd_data[k*DATA_W +: DATA_W] = bus.wd1;
         end else if (hit0) begin
            bus.rd_data[k*DATA_W +: DATA_W] = bus.wd0;
         end else begin
            bus.rd_data[k*DATA_W +: DATA_W] = regs_q[ra];
         end
         bus.rd_busy[k] = busy_q[ra] && !hit0 && !hit1;
      end
   end

   assign bus.busy_cnt = cnt_q;

`ifdef GRF_TRACE_EN
   always @(posedge clk) begin
      if (we0_eff && !(we1_eff && (bus.wa1 == bus.wa0)))
         $display("%0t@%h: $%0d <= %h", $time, bus.wpc0, bus.wa0, bus.wd0);
      if (we1_eff)
         $display("%0t@%h: $%0d <= %h", $time, bus.wpc1, bus.wa1, bus.wd1);
   end
`else
   logic unused_pc;
   assign unused_pc = ^{bus.wpc0, bus.wpc1};
`endif
endmodule

// File: tb/tb_grf_mp.sv
// Directed self-checking bench for grf_mp: forwarding, port priority, scoreboard and async reset.
module tb_grf_mp;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADDR_W = 5;
   localparam int unsigned NUM_RD = 2;

   logic clk;
   logic reset;
   int   n_checks = 0;
   int   n_errors = 0;

   grf_mp_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) gif ();

   grf_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (gif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic idle();
      gif.we0 = 1'b0; gif.wa0 = '0; gif.wd0 = '0; gif.wpc0 = '0;
      gif.we1 = 1'b0; gif.wa1 = '0; gif.wd1 = '0; gif.wpc1 = '0;
      gif.iss_en = 1'b0; gif.iss_addr = '0;
   endtask

   task automatic rd(input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1);
      gif.rd_addr = {a1, a0};
   endtask

   // Advance one edge and land 1 time unit after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] d0();
      return 64'(gif.rd_data[0 +: DATA_W]);
   endfunction

   function automatic logic [63:0] d1();
      return 64'(gif.rd_data[DATA_W +: DATA_W]);
   endfunction

   initial begin
      idle();
      rd(5'd5, 5'd0);
      reset = 1'b1;
      gif.we0 = 1'b1; gif.wa0 = 5'd5; gif.wd0 = 32'hDEAD_BEEF;
      #3;
      check("rst_rd0_no_fwd", d0(), 64'h0);
      check("rst_cnt", 64'(gif.busy_cnt), 64'h0);
      check("rst_busy", 64'(gif.rd_busy), 64'h0);
      step();
      check("rst_rd0_after_edge", d0(), 64'h0);
      reset = 1'b0;

      // Forwarding and register 0
      gif.we0 = 1'b1; gif.wa0 = 5'd5; gif.wd0 = 32'h1234_5678; gif.wpc0 = 32'h100;
      #1;
      check("fwd_rd0", d0(), 64'h1234_5678);
      check("fwd_rd1_r0", d1(), 64'h0);
      step();
      idle();
      #1;
      check("stored_r5", d0(), 64'h1234_5678);

      // Dual-write same address: port 1 wins
      rd(5'd7, 5'd5);
      gif.we0 = 1'b1; gif.wa0 = 5'd7; gif.wd0 = 32'hAAAA_0000; gif.wpc0 = 32'h200;
      gif.we1 = 1'b1; gif.wa1 = 5'd7; gif.wd1 = 32'h5555_FFFF; gif.wpc1 = 32'h204;
      #1;
      check("dual_fwd", d0(), 64'h5555_FFFF);
      step();
      idle();
      #1;
      check("dual_stored", d0(), 64'h5555_FFFF);
      check("dual_r5_kept", d1(), 64'h1234_5678);

      // Scoreboard lifecycle on register 9
      rd(5'd9, 5'd7);
      gif.iss_en = 1'b1; gif.iss_addr = 5'd9;
      #1;
      check("iss_same_cycle_busy", 64'(gif.rd_busy), 64'h0);
      step();
      idle();
      #1;
      check("sb_busy1", 64'(gif.rd_busy), 64'h1);
      check("sb_cnt1", 64'(gif.busy_cnt), 64'd1);
      step();
      check("sb_busy2", 64'(gif.rd_busy), 64'h1);
      gif.we0 = 1'b1; gif.wa0 = 5'd9; gif.wd0 = 32'hCAFE_0009;
      #1;
      check("sb_wb_busy", 64'(gif.rd_busy), 64'h0);
      check("sb_wb_fwd", d0(), 64'hCAFE_0009);
      check("sb_wb_cnt_pre", 64'(gif.busy_cnt), 64'd1);
      step();
      idle();
      #1;
      check("sb_cnt0", 64'(gif.busy_cnt), 64'd0);
      check("sb_stored", d0(), 64'hCAFE_0009);

      // Simultaneous issue and write-back on register 3 (re-issue while busy first)
      rd(5'd3, 5'd9);
      gif.iss_en = 1'b1; gif.iss_addr = 5'd3;
      step();
      step();
      check("re_iss_cnt", 64'(gif.busy_cnt), 64'd1);
      gif.we1 = 1'b1; gif.wa1 = 5'd3; gif.wd1 = 32'h0000_0033;
      gif.iss_en = 1'b1; gif.iss_addr = 5'd3;
      step();
      idle();
      #1;
      check("iss_wb_busy", 64'(gif.rd_busy), 64'h1);
      check("iss_wb_cnt", 64'(gif.busy_cnt), 64'd1);
      check("iss_wb_data", d0(), 64'h33);
      gif.we0 = 1'b1; gif.wa0 = 5'd3; gif.wd0 = 32'h0000_0034;
      step();
      idle();
      #1;
      check("r3_clean_cnt", 64'(gif.busy_cnt), 64'd0);

      // Register 0 writes and issues ignored
      rd(5'd0, 5'd3);
      gif.we0 = 1'b1; gif.wa0 = 5'd0; gif.wd0 = 32'hFFFF_FFFF;
      gif.iss_en = 1'b1; gif.iss_addr = 5'd0;
      #1;
      check("r0_fwd", d0(), 64'h0);
      step();
      idle();
      #1;
      check("r0_read", d0(), 64'h0);
      check("r0_busy", 64'(gif.rd_busy), 64'h0);
      check("r0_cnt", 64'(gif.busy_cnt), 64'd0);

      // Four busy registers, then async reset pulse between edges
      for (int i = 10; i < 14; i++) begin
         gif.iss_en = 1'b1; gif.iss_addr = 5'(i);
         step();
      end
      idle();
      rd(5'd10, 5'd13);
      #1;
      check("four_cnt", 64'(gif.busy_cnt), 64'd4);
      check("four_busy", 64'(gif.rd_busy), 64'h3);
      rd(5'd10, 5'd5);
      #1;
      reset = 1'b1;
      #1;
      check("arst_cnt", 64'(gif.busy_cnt), 64'd0);
      check("arst_busy", 64'(gif.rd_busy), 64'h0);
      check("arst_r5", d1(), 64'h0);
      #1;
      reset = 1'b0;
      rd(5'd7, 5'd9);
      step();
      check("post_rst_r7", d0(), 64'h0);
      check("post_rst_r9", d1(), 64'h0);
      check("post_rst_cnt", 64'(gif.busy_cnt), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
